// File: rtl/frame_buffer_arbiter_if.sv
// Host drawing port of frame_buffer_arbiter: a req/ack handshake carrying one
// 24-bit RAM word (8 pixels x 3 bits) per transaction.
//   master : host side, drives hostReq/hostWe/hostAddr/hostWdata, receives hostAck/hostRdata
//   slave  : arbiter side
// The host holds hostReq and its request fields stable until it sees hostAck.
interface frame_buffer_arbiter_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 24;

  logic              hostReq;
  logic              hostWe;
  logic [ADDR_W-1:0] hostAddr;
  logic [DATA_W-1:0] hostWdata;
  logic              hostAck;
  logic [DATA_W-1:0] hostRdata;

  modport master (
    output hostReq, hostWe, hostAddr, hostWdata,
    input  hostAck, hostRdata
  );

  modport slave (
    input  hostReq, hostWe, hostAddr, hostWdata,
    output hostAck, hostRdata
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Shares one single-port frame-buffer RAM between VGA scan-out and a host port.
// Display fetches have absolute priority; every other cycle may serve the host.
// Each fetch reads one word of 8 pixels (pixel k in bits [3k+2:3k]) one group
// ahead of the beam; the word is double-buffered (nextWord -> curWord) and
// serialised into a registered 3-bit color, with syncs delayed to match.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   row, column              scan position from the VGA controller
//   displayActive            high inside the visible area
//   hSyncIn, vSyncIn         syncs from the VGA controller
//   color, hSync, vSync      registered pixel color and 1-clk delayed syncs
//   ramEn, ramWe, ramAddr,
//   ramWdata                 RAM command (combinational), addr = {row, word}
//   ramRdata                 RAM read data, valid 1 clk after a read strobe
//   host                     host req/ack port (slave side)
module frame_buffer_arbiter #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned FETCH_PHASE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  row,
  input  logic [9:0]  column,
  input  logic        displayActive,
  input  logic        hSyncIn,
  input  logic        vSyncIn,
  output logic [2:0]  color,
  output logic        hSync,
  output logic        vSync,
  output logic        ramEn,
  output logic        ramWe,
  output logic [15:0] ramAddr,
  output logic [23:0] ramWdata,
  input  logic [23:0] ramRdata,
  frame_buffer_arbiter_if.slave host
);

  localparam int unsigned ROW_W  = 9;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned WORD_W = 7;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned WORDS  = H_ACTIVE / 8;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    HOST_ACK = 1'b1
  } state_t;

  state_t              state;
  logic                hostAckQ;
  logic [DATA_W-1:0]   curWord;
  logic [DATA_W-1:0]   nextWord;
  logic                fetchPending;

  logic                fetchSlot;
  logic                hostGrant;
  logic                inActiveCols;
  logic                lastGroup;
  logic [WORD_W-1:0]   wordIdx;
  logic [WORD_W:0]     tgtIdx;
  logic [ROW_W-1:0]    fetchRow;
  logic [WORD_W-1:0]   fetchWord;
  logic [4:0]          pixLsb;
  logic [DATA_W-1:0]   pixShift;

  // Fetch slot decode: one slot per 8-column group, one group ahead of the beam.
  assign wordIdx      = column[COL_W-1:3];
  assign tgtIdx       = {1'b0, wordIdx} + (WORD_W+1)'(1);
  assign lastGroup    = (tgtIdx == (WORD_W+1)'(WORDS));
  assign inActiveCols = (column < COL_W'(H_ACTIVE));

  // The last blanking row only prefetches word 0 of row 0 for the next frame.
  always_comb begin
    fetchSlot = 1'b0;
    if ((column[2:0] == 3'(FETCH_PHASE)) && inActiveCols) begin
      if (row < ROW_W'(V_ACTIVE)) begin
        fetchSlot = 1'b1;
      end else if ((row == ROW_W'(V_TOTAL - 1)) && lastGroup) begin
        fetchSlot = 1'b1;
      end
    end
  end

  // Fetch target: next word of this row, or word 0 of the following row.
  always_comb begin
    fetchRow  = row;
    fetchWord = tgtIdx[WORD_W-1:0];
    if (lastGroup) begin
      fetchWord = '0;
      if ((row == ROW_W'(V_ACTIVE - 1)) || (row == ROW_W'(V_TOTAL - 1))) begin
        fetchRow = '0;
      end else begin
        fetchRow = row + ROW_W'(1);
      end
    end
  end

  // RAM command mux; the host only gets cycles the display does not need.
  always_comb begin
    ramEn     = 1'b0;
    ramWe     = 1'b0;
    ramAddr   = {fetchRow, fetchWord};
    hostGrant = 1'b0;
    if (!rst) begin
      if (fetchSlot) begin
        ramEn = 1'b1;
      end else if ((state == IDLE) && host.hostReq) begin
        ramEn     = 1'b1;
        ramWe     = host.hostWe;
        ramAddr   = host.hostAddr;
        hostGrant = 1'b1;
      end
    end
  end

  assign ramWdata       = host.hostWdata;
  assign host.hostAck   = hostAckQ;
  assign host.hostRdata = ramRdata;

  // Pixel select within the current word.
  assign pixLsb   = 5'(column[2:0]) * 5'd3;
  assign pixShift = curWord >> pixLsb;

  // Host FSM, word double-buffer, color and sync pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hostAckQ     <= 1'b0;
      color        <= 3'd0;
      hSync        <= 1'b1;
      vSync        <= 1'b1;
      curWord      <= '0;
      nextWord     <= '0;
      fetchPending <= 1'b0;
    end else begin
      hSync        <= hSyncIn;
      vSync        <= vSyncIn;
      color        <= displayActive ? pixShift[2:0] : 3'd0;
      fetchPending <= fetchSlot;
      if (fetchPending) begin
        nextWord <= ramRdata;
      end
      // Hand off at the end of each group so curWord holds word k for columns 8k..8k+7.
      if ((column[2:0] == 3'd7) && inActiveCols) begin
        curWord <= nextWord;
      end
      case (state)
        IDLE: begin
          if (hostGrant) begin
            state    <= HOST_ACK;
            hostAckQ <= 1'b1;
          end
        end
        HOST_ACK: begin
          state    <= IDLE;
          hostAckQ <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          hostAckQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Self-checking bench for frame_buffer_arbiter: behavioural RAM, scan position
// driven directly by the bench, scoreboards for host transactions and pixels.
module tb_frame_buffer_arbiter;

  logic        clk;
  logic        rst;
  logic [8:0]  row;
  logic [9:0]  column;
  logic        displayActive;
  logic        hSyncIn;
  logic        vSyncIn;
  logic [2:0]  color;
  logic        hSync;
  logic        vSync;
  logic        ramEn;
  logic        ramWe;
  logic [15:0] ramAddr;
  logic [23:0] ramWdata;
  logic [23:0] ramRdata;

  logic        bdWe;
  logic [15:0] bdAddr;
  logic [23:0] bdData;
  logic [23:0] mem [0:65535];

  int checks;
  int errors;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [23:0] data;
  } host_exp_t;

  typedef struct {
    logic [2:0] color;
    logic       hs;
    logic       vs;
  } pix_exp_t;

  host_exp_t hostQ[$];
  pix_exp_t  pixQ[$];

  frame_buffer_arbiter_if hif();

  frame_buffer_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .row           (row),
    .column        (column),
    .displayActive (displayActive),
    .hSyncIn       (hSyncIn),
    .vSyncIn       (vSyncIn),
    .color         (color),
    .hSync         (hSync),
    .vSync         (vSync),
    .ramEn         (ramEn),
    .ramWe         (ramWe),
    .ramAddr       (ramAddr),
    .ramWdata      (ramWdata),
    .ramRdata      (ramRdata),
    .host          (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with a backdoor preload port.
  always @(posedge clk) begin
    if (bdWe) mem[bdAddr] <= bdData;
    if (ramEn) begin
      if (ramWe) mem[ramAddr] <= ramWdata;
      else       ramRdata <= mem[ramAddr];
    end
  end

  task automatic update_syncs();
    displayActive = (row < 9'd480) && (column < 10'd640);
    hSyncIn       = !((column >= 10'd656) && (column < 10'd752));
    vSyncIn       = !((row >= 9'd490) && (row < 9'd492));
  endtask

  task automatic set_scan(input int r, input int c);
    row    = 9'(r);
    column = 10'(c);
    update_syncs();
  endtask

  // Advance one clock; scan inputs change 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (column == 10'd799) begin
      column = 10'd0;
      row    = (row == 9'd524) ? 9'd0 : row + 9'd1;
    end else begin
      column = column + 10'd1;
    end
    update_syncs();
  endtask

  task automatic preload(input logic [15:0] a, input logic [23:0] d);
    bdWe = 1'b1; bdAddr = a; bdData = d;
    @(posedge clk);
    #1;
    bdWe = 1'b0;
  endtask

  // Reference display-fetch schedule.
  function automatic void fetch_model(input logic [8:0] r, input logic [9:0] c,
                                      output bit en, output logic [15:0] a);
    int w;
    int nr;
    en = 1'b0;
    a  = 16'h0;
    w  = int'(c) / 8 + 1;
    nr = int'(r);
    if (w == 80) begin
      w  = 0;
      nr = (r == 9'd479 || r == 9'd524) ? 0 : int'(r) + 1;
    end
    if ((int'(c) % 8 == 2) && (c < 10'd640) &&
        ((r < 9'd480) || (r == 9'd524 && int'(c) / 8 == 79))) begin
      en = 1'b1;
      a  = 16'(nr * 128 + w);
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    hif.hostReq = 1'b1; hif.hostWe = 1'b1;
    hif.hostAddr = 16'h0010; hif.hostWdata = 24'hFFFFFF;
    set_scan(490, 700);
    #1;
    checks++;
    if (ramEn !== 1'b0 || ramWe !== 1'b0)
      begin errors++; $display("FAIL reset_ram_quiet: ramEn=%b ramWe=%b want 0 0", ramEn, ramWe); end
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (color !== 3'd0) begin errors++; $display("FAIL reset_color: got %0d want 0", color); end
    checks++;
    if (hSync !== 1'b1 || vSync !== 1'b1)
      begin errors++; $display("FAIL reset_sync: hSync=%b vSync=%b want 1 1", hSync, vSync); end
    checks++;
    if (hif.hostAck !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", hif.hostAck); end
    hif.hostReq = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (hif.hostAck !== 1'b0 || ramEn !== 1'b0)
      begin errors++; $display("FAIL reset_release: hostAck=%b ramEn=%b want 0 0", hif.hostAck, ramEn); end
  endtask

  // Prefetch across the frame wrap: row 524 loads word 0 of row 0.
  task automatic test_display_prefetch();
    logic [23:0] words [0:2];
    logic [23:0] w;
    pix_exp_t    p;
    bit          fen;
    logic [15:0] fa;
    words[0] = 24'o76543210;
    words[1] = 24'o01234567;
    words[2] = 24'o35172604;
    for (int k = 0; k < 3; k++) preload(16'(k), words[k]);
    pixQ.delete();
    next_cycle();
    set_scan(524, 600);
    for (int n = 0; n < 224; n++) begin
      #1;
      if (pixQ.size() > 0) begin
        p = pixQ.pop_front();
        checks++;
        if (color !== p.color || hSync !== p.hs || vSync !== p.vs)
          begin errors++; $display("FAIL pixel r%0d c%0d: color=%0d hs=%b vs=%b want %0d %b %b",
                                   row, column, color, hSync, vSync, p.color, p.hs, p.vs); end
      end
      fetch_model(row, column, fen, fa);
      checks++;
      if (ramEn !== fen || (fen && (ramWe !== 1'b0 || ramAddr !== fa)))
        begin errors++; $display("FAIL display_fetch r%0d c%0d: en=%b addr=%h want %b %h",
                                 row, column, ramEn, ramAddr, fen, fa); end
      p.hs = hSyncIn;
      p.vs = vSyncIn;
      p.color = 3'd0;
      if (displayActive && row == 9'd0 && column < 10'd24) begin
        w = words[column / 10'd8];
        p.color = w[3 * int'(column % 10'd8) +: 3];
      end
      pixQ.push_back(p);
      next_cycle();
    end
  endtask

  // Back-to-back writes with hostReq held high.
  task automatic test_host_stream();
    host_exp_t   e;
    bit          fen;
    logic [15:0] fa;
    logic        expAck;
    logic        grant;
    int          acks, lastAck, cyc, idx;
    hostQ.delete();
    next_cycle();
    set_scan(10, 1);
    idx = 0; acks = 0; lastAck = -1; cyc = 0; expAck = 1'b0;
    hif.hostReq = 1'b1; hif.hostWe = 1'b1;
    hif.hostAddr = 16'h0100; hif.hostWdata = 24'hA00000;
    while (acks < 4 && cyc < 40) begin
      #1;
      checks++;
      if (hif.hostAck !== expAck)
        begin errors++; $display("FAIL stream_ack cyc %0d: got %b want %b", cyc, hif.hostAck, expAck); end
      if (hif.hostAck === 1'b1 && hostQ.size() > 0) begin
        e = hostQ.pop_front();
        checks++;
        if (mem[e.addr] !== e.data)
          begin errors++; $display("FAIL stream_wdata %h: got %h want %h", e.addr, mem[e.addr], e.data); end
        if (lastAck >= 0) begin
          checks++;
          if (cyc - lastAck != 2)
            begin errors++; $display("FAIL stream_rate: ack gap %0d want 2", cyc - lastAck); end
        end
        lastAck = cyc; acks++; idx++;
        if (idx < 4) begin
          hif.hostAddr  = 16'h0100 + 16'(idx);
          hif.hostWdata = 24'hA00000 + 24'(idx);
        end else begin
          hif.hostReq = 1'b0;
        end
      end
      #1;
      fetch_model(row, column, fen, fa);
      grant = !fen && hif.hostReq && !expAck;
      checks++;
      if (fen) begin
        if (ramEn !== 1'b1 || ramWe !== 1'b0 || ramAddr !== fa)
          begin errors++; $display("FAIL stream_fetch c%0d: en=%b we=%b addr=%h want 1 0 %h",
                                   column, ramEn, ramWe, ramAddr, fa); end
      end else if (grant) begin
        if (ramEn !== 1'b1 || ramWe !== 1'b1 || ramAddr !== hif.hostAddr || ramWdata !== hif.hostWdata)
          begin errors++; $display("FAIL stream_grant c%0d: en=%b we=%b addr=%h want 1 1 %h",
                                   column, ramEn, ramWe, ramAddr, hif.hostAddr); end
        e.we = 1'b1; e.addr = hif.hostAddr; e.data = hif.hostWdata;
        hostQ.push_back(e);
      end else if (ramEn !== 1'b0) begin
        errors++; $display("FAIL stream_idle c%0d: ramEn=%b want 0", column, ramEn);
      end
      expAck = grant;
      next_cycle();
      cyc++;
    end
    checks++;
    if (acks != 4) begin errors++; $display("FAIL stream_timeout: acks %0d want 4", acks); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0100 + 16'(i)] !== 24'hA00000 + 24'(i))
        begin errors++; $display("FAIL stream_mem %0d: got %h want %h", i,
                                 mem[16'h0100 + 16'(i)], 24'hA00000 + 24'(i)); end
    end
  endtask

  // Request rises exactly on the fetch phase: fetch wins, host next clk.
  task automatic test_fetch_collision();
    host_exp_t e;
    next_cycle();
    set_scan(10, 18);
    hif.hostReq = 1'b1; hif.hostWe = 1'b1;
    hif.hostAddr = 16'h0300; hif.hostWdata = 24'h0BEEF0;
    #1;
    checks++;
    if (ramEn !== 1'b1 || ramWe !== 1'b0 || ramAddr !== 16'h0503)
      begin errors++; $display("FAIL collide_fetch: en=%b we=%b addr=%h want 1 0 0503", ramEn, ramWe, ramAddr); end
    next_cycle();
    #1;
    checks++;
    if (hif.hostAck !== 1'b0 || ramEn !== 1'b1 || ramWe !== 1'b1 || ramAddr !== 16'h0300)
      begin errors++; $display("FAIL collide_grant: ack=%b en=%b we=%b addr=%h want 0 1 1 0300",
                               hif.hostAck, ramEn, ramWe, ramAddr); end
    e.we = 1'b1; e.addr = 16'h0300; e.data = 24'h0BEEF0;
    hostQ.push_back(e);
    next_cycle();
    #1;
    checks++;
    if (hif.hostAck !== 1'b1) begin errors++; $display("FAIL collide_ack_latency: got %b want 1", hif.hostAck); end
    e = hostQ.pop_front();
    checks++;
    if (mem[e.addr] !== e.data)
      begin errors++; $display("FAIL collide_wdata: got %h want %h", mem[e.addr], e.data); end
    hif.hostReq = 1'b0;
    next_cycle();
  endtask

  // Reads in blanking, the second chained through the ack cycle.
  task automatic test_host_read();
    host_exp_t e;
    preload(16'h0205, 24'h123456);
    next_cycle();
    set_scan(500, 0);
    hif.hostReq = 1'b1; hif.hostWe = 1'b0; hif.hostAddr = 16'h0205;
    #1;
    checks++;
    if (ramEn !== 1'b1 || ramWe !== 1'b0 || ramAddr !== 16'h0205)
      begin errors++; $display("FAIL read_grant: en=%b we=%b addr=%h want 1 0 0205", ramEn, ramWe, ramAddr); end
    e.we = 1'b0; e.addr = 16'h0205; e.data = 24'h123456;
    hostQ.push_back(e);
    next_cycle();
    #1;
    checks++;
    if (hif.hostAck !== 1'b1) begin errors++; $display("FAIL read_ack: got %b want 1", hif.hostAck); end
    e = hostQ.pop_front();
    checks++;
    if (hif.hostRdata !== e.data)
      begin errors++; $display("FAIL read_data: got %h want %h", hif.hostRdata, e.data); end
    hif.hostAddr = 16'h0100;
    e.addr = 16'h0100; e.data = 24'hA00000;
    hostQ.push_back(e);
    #1;
    checks++;
    if (ramEn !== 1'b0) begin errors++; $display("FAIL read_ack_no_grant: ramEn=%b want 0", ramEn); end
    next_cycle();
    #1;
    checks++;
    if (hif.hostAck !== 1'b0 || ramEn !== 1'b1 || ramAddr !== 16'h0100)
      begin errors++; $display("FAIL read_chain_grant: ack=%b en=%b addr=%h want 0 1 0100",
                               hif.hostAck, ramEn, ramAddr); end
    next_cycle();
    #1;
    checks++;
    if (hif.hostAck !== 1'b1) begin errors++; $display("FAIL read_chain_ack: got %b want 1", hif.hostAck); end
    e = hostQ.pop_front();
    checks++;
    if (hif.hostRdata !== e.data)
      begin errors++; $display("FAIL read_chain_data: got %h want %h", hif.hostRdata, e.data); end
    hif.hostReq = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (hif.hostAck !== 1'b0) begin errors++; $display("FAIL read_ack_pulse: got %b want 0", hif.hostAck); end
  endtask

  // Last group of row 479 wraps to row 0; rows 480..523 fetch nothing.
  task automatic test_row_wrap();
    bit          fen;
    logic [15:0] fa;
    int          bad;
    int          cyc;
    bad = 0; cyc = 0;
    hif.hostReq = 1'b0;
    next_cycle();
    set_scan(479, 626);
    while (!(row == 9'd524 && column == 10'd0) && cyc < 40000) begin
      #1;
      fetch_model(row, column, fen, fa);
      if (row == 9'd479 && column == 10'd634) begin
        checks++;
        if (ramEn !== 1'b1 || ramAddr !== 16'h0000)
          begin errors++; $display("FAIL wrap_addr: en=%b addr=%h want 1 0000", ramEn, ramAddr); end
      end
      if (ramEn !== fen) bad++;
      next_cycle();
      cyc++;
    end
    checks++;
    if (cyc >= 40000) begin errors++; $display("FAIL wrap_timeout: %0d cycles", cyc); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL blank_rows_fetch: %0d bad cycles want 0", bad); end
  endtask

  // Reset while HOST_ACK, then reset in the grant cycle (access dropped).
  task automatic test_reset_in_flight();
    preload(16'h0400, 24'h111111);
    preload(16'h0401, 24'h222222);
    next_cycle();
    set_scan(490, 700);
    hif.hostReq = 1'b1; hif.hostWe = 1'b1;
    hif.hostAddr = 16'h0400; hif.hostWdata = 24'h777777;
    #1;
    checks++;
    if (ramEn !== 1'b1 || ramWe !== 1'b1)
      begin errors++; $display("FAIL rst_pre_grant: en=%b we=%b want 1 1", ramEn, ramWe); end
    next_cycle();
    rst = 1'b1;
    #1;
    checks++;
    if (hif.hostAck !== 1'b1) begin errors++; $display("FAIL rst_ack_cycle: got %b want 1", hif.hostAck); end
    checks++;
    if (ramEn !== 1'b0) begin errors++; $display("FAIL rst_ram_quiet: ramEn=%b want 0", ramEn); end
    next_cycle();
    rst = 1'b0;
    hif.hostReq = 1'b0;
    #1;
    checks++;
    if (hif.hostAck !== 1'b0) begin errors++; $display("FAIL rst_no_ack: got %b want 0", hif.hostAck); end
    checks++;
    if (color !== 3'd0 || hSync !== 1'b1 || vSync !== 1'b1)
      begin errors++; $display("FAIL rst_outputs: color=%0d hSync=%b vSync=%b want 0 1 1", color, hSync, vSync); end
    hif.hostReq = 1'b1; hif.hostAddr = 16'h0401; hif.hostWdata = 24'h555555;
    rst = 1'b1;
    #1;
    checks++;
    if (ramEn !== 1'b0) begin errors++; $display("FAIL drop_ram_quiet: ramEn=%b want 0", ramEn); end
    next_cycle();
    rst = 1'b0;
    hif.hostReq = 1'b0;
    #1;
    checks++;
    if (hif.hostAck !== 1'b0) begin errors++; $display("FAIL drop_no_ack: got %b want 0", hif.hostAck); end
    checks++;
    if (mem[16'h0401] !== 24'h222222)
      begin errors++; $display("FAIL drop_no_write: got %h want 222222", mem[16'h0401]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bdWe = 1'b0; bdAddr = 16'h0; bdData = 24'h0;
    rst = 1'b1;
    hif.hostReq = 1'b0; hif.hostWe = 1'b0;
    hif.hostAddr = 16'h0; hif.hostWdata = 24'h0;
    set_scan(0, 0);
    test_reset();
    test_display_prefetch();
    test_host_stream();
    test_fetch_collision();
    test_host_read();
    test_row_wrap();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
